// File: rtl/simple_mem_arb_if.sv
// simple_mem_arb_if: bundle of the two requester ports and the shared memory port.
// master = arbiter view, slave = requesters plus memory (err only with SIMPLE_MEM_ARB_TIMEOUT_EN).
interface simple_mem_arb_if;
  logic [31:0] m0_addr;
  logic [31:0] m0_wd;
  logic        m0_we;
  logic [1:0]  m0_size;
  logic        m0_req;
  logic [31:0] m0_rd;
  logic        m0_req_ack;

  logic [31:0] m1_addr;
  logic [31:0] m1_wd;
  logic        m1_we;
  logic [1:0]  m1_size;
  logic        m1_req;
  logic [31:0] m1_rd;
  logic        m1_req_ack;

  logic [31:0] s_addr;
  logic [31:0] s_wd;
  logic        s_we;
  logic [1:0]  s_size;
  logic        s_req;
  logic [31:0] s_rd;
  logic        s_req_ack;

  logic        busy;
  logic        owner;
`ifdef SIMPLE_MEM_ARB_TIMEOUT_EN
  logic        err;
`endif

  modport master (
    input  m0_addr, m0_wd, m0_we, m0_size, m0_req,
    output m0_rd, m0_req_ack,
    input  m1_addr, m1_wd, m1_we, m1_size, m1_req,
    output m1_rd, m1_req_ack,
    output s_addr, s_wd, s_we, s_size, s_req,
    input  s_rd, s_req_ack,
`ifdef SIMPLE_MEM_ARB_TIMEOUT_EN
    output err,
`endif
    output busy, owner
  );

  modport slave (
    output m0_addr, m0_wd, m0_we, m0_size, m0_req,
    input  m0_rd, m0_req_ack,
    output m1_addr, m1_wd, m1_we, m1_size, m1_req,
    input  m1_rd, m1_req_ack,
    input  s_addr, s_wd, s_we, s_size, s_req,
    output s_rd, s_req_ack,
`ifdef SIMPLE_MEM_ARB_TIMEOUT_EN
    input  err,
`endif
    input  busy, owner
  );
endinterface

// File: rtl/simple_mem_arb.sv
// simple_mem_arb: two-master arbiter for one memory port, one transaction at a time.
// Optional busy timeout with forced completion: define SIMPLE_MEM_ARB_TIMEOUT_EN.
module simple_mem_arb #(
  parameter int FIX_PRIO = 0
`ifdef SIMPLE_MEM_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input  logic              clk,
  input  logic              resetn,
  simple_mem_arb_if.master  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_q, last_d;
  logic   win;

`ifdef SIMPLE_MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          expire;
`endif

  // pick the master to grant when the port is free
  always_comb begin
    win = 1'b0;
    if (bus.m0_req && bus.m1_req) begin
      win = (FIX_PRIO != 0) ? 1'b0 : ~last_q;
    end else begin
      win = bus.m1_req;
    end
  end

  // next state, grant bookkeeping and all bus outputs
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_d         = last_q;
    bus.s_addr     = '0;
    bus.s_wd       = '0;
    bus.s_we       = 1'b0;
    bus.s_size     = '0;
    bus.s_req      = 1'b0;
    bus.busy       = 1'b0;
    bus.m0_rd      = '0;
    bus.m1_rd      = '0;
    bus.m0_req_ack = 1'b0;
    bus.m1_req_ack = 1'b0;
`ifdef SIMPLE_MEM_ARB_TIMEOUT_EN
    cnt_d          = cnt_q;
    expire         = 1'b0;
    bus.err        = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          state_d = BUSY;
          owner_d = win;
`ifdef SIMPLE_MEM_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
        bus.busy   = 1'b1;
        bus.s_req  = 1'b1;
        bus.s_addr = owner_q ? bus.m1_addr : bus.m0_addr;
        bus.s_wd   = owner_q ? bus.m1_wd   : bus.m0_wd;
        bus.s_we   = owner_q ? bus.m1_we   : bus.m0_we;
        bus.s_size = owner_q ? bus.m1_size : bus.m0_size;
`ifdef SIMPLE_MEM_ARB_TIMEOUT_EN
        expire = !bus.s_req_ack && (cnt_q == CW'(TIMEOUT));
        if (expire) begin
          bus.s_req = 1'b0;
          bus.err   = 1'b1;
          if (owner_q) begin
            bus.m1_req_ack = 1'b1;
            bus.m1_rd      = 32'hDEAD_BEEF;
          end else begin
            bus.m0_req_ack = 1'b1;
            bus.m0_rd      = 32'hDEAD_BEEF;
          end
          state_d = IDLE;
          last_d  = owner_q;
        end else begin
          if (owner_q) begin
            bus.m1_req_ack = bus.s_req_ack;
            bus.m1_rd      = bus.s_rd;
          end else begin
            bus.m0_req_ack = bus.s_req_ack;
            bus.m0_rd      = bus.s_rd;
          end
          if (bus.s_req_ack) begin
            state_d = IDLE;
            last_d  = owner_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`else
        if (owner_q) begin
          bus.m1_req_ack = bus.s_req_ack;
          bus.m1_rd      = bus.s_rd;
        end else begin
          bus.m0_req_ack = bus.s_req_ack;
          bus.m0_rd      = bus.s_rd;
        end
        if (bus.s_req_ack) begin
          state_d = IDLE;
          last_d  = owner_q;
        end
`endif
      end
    endcase
  end

  assign bus.owner = owner_q;

  // state, grant and round-robin history registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

`ifdef SIMPLE_MEM_ARB_TIMEOUT_EN
  // cycles spent waiting on the slave in the current transaction
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_simple_mem_arb.sv
// tb_simple_mem_arb: directed and random scenarios against a transaction model.
// Checks both round-robin and fixed-priority instances.
module tb_simple_mem_arb;

  typedef logic [136:0] ovec_t;
  localparam int A0_BIT = 67;
  localparam int A1_BIT = 34;
`ifdef SIMPLE_MEM_ARB_TIMEOUT_EN
  localparam int TO = 4;
`endif

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  simple_mem_arb_if ia ();
  simple_mem_arb_if ib ();

  simple_mem_arb #(
    .FIX_PRIO(0)
`ifdef SIMPLE_MEM_ARB_TIMEOUT_EN
    , .TIMEOUT(TO)
`endif
  ) dut_rr (
    .clk(clk),
    .resetn(resetn),
    .bus(ia)
  );

  simple_mem_arb #(
    .FIX_PRIO(1)
  ) dut_fx (
    .clk(clk),
    .resetn(resetn),
    .bus(ib)
  );

  int n_cmp = 0;
  int n_bad = 0;
  ovec_t got, exp;

  // model: is a transaction open, who holds it, who won last, cycles waited
  bit mb_busy, mb_own, mb_last;
  int mb_cnt;

  function automatic void model_reset();
    mb_busy = 1'b0;
    mb_own  = 1'b0;
    mb_last = 1'b1;
    mb_cnt  = 0;
  endfunction

  function automatic bit to_fire();
`ifdef SIMPLE_MEM_ARB_TIMEOUT_EN
    return mb_busy && !ia.s_req_ack && (mb_cnt == TO);
`else
    return 1'b0;
`endif
  endfunction

  function automatic ovec_t model_out();
    logic sr, bs, we, a0, a1, f;
    logic [1:0] sz;
    logic [31:0] ad, wd, r0, r1;
    {sr, bs, we, a0, a1} = '0;
    sz = '0; ad = '0; wd = '0; r0 = '0; r1 = '0;
    f = to_fire();
    if (mb_busy) begin
      bs = 1'b1;
      sr = !f;
      ad = mb_own ? ia.m1_addr : ia.m0_addr;
      wd = mb_own ? ia.m1_wd : ia.m0_wd;
      we = mb_own ? ia.m1_we : ia.m0_we;
      sz = mb_own ? ia.m1_size : ia.m0_size;
      if (mb_own) begin
        a1 = f | ia.s_req_ack;
        r1 = f ? 32'hDEADBEEF : ia.s_rd;
      end else begin
        a0 = f | ia.s_req_ack;
        r0 = f ? 32'hDEADBEEF : ia.s_rd;
      end
    end
    return {sr, bs, we, sz, ad, wd, a0, r0, a1, r1, mb_own, f};
  endfunction

  function automatic void model_step();
    bit f;
    f = to_fire();
    if (!mb_busy) begin
      if (ia.m0_req || ia.m1_req) begin
        mb_busy = 1'b1;
        mb_own  = (ia.m0_req && ia.m1_req) ? !mb_last : ia.m1_req;
        mb_cnt  = 0;
      end
    end else if (ia.s_req_ack || f) begin
      mb_busy = 1'b0;
      mb_last = mb_own;
    end else begin
      mb_cnt++;
    end
  endfunction

  function automatic ovec_t pack_dut();
    logic e;
    e = 1'b0;
`ifdef SIMPLE_MEM_ARB_TIMEOUT_EN
    e = ia.err;
`endif
    return {ia.s_req, ia.busy, ia.s_we, ia.s_size, ia.s_addr, ia.s_wd,
            ia.m0_req_ack, ia.m0_rd, ia.m1_req_ack, ia.m1_rd, ia.owner, e};
  endfunction

  task automatic init_inputs();
    ia.m0_addr = '0; ia.m0_wd = '0; ia.m0_we = 0; ia.m0_size = '0; ia.m0_req = 0;
    ia.m1_addr = '0; ia.m1_wd = '0; ia.m1_we = 0; ia.m1_size = '0; ia.m1_req = 0;
    ia.s_rd = '0; ia.s_req_ack = 0;
    ib.m0_addr = '0; ib.m0_wd = '0; ib.m0_we = 0; ib.m0_size = '0; ib.m0_req = 0;
    ib.m1_addr = '0; ib.m1_wd = '0; ib.m1_we = 0; ib.m1_size = '0; ib.m1_req = 0;
    ib.s_rd = '0; ib.s_req_ack = 0;
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    init_inputs();
    model_reset();
    #1;
    got = pack_dut();
    n_cmp++;
    if (got !== '0) begin
      n_bad++;
      $display("FAIL reset_rr got=%h exp=0", got);
    end
    n_cmp++;
    if ({ib.s_req, ib.busy, ib.m0_req_ack, ib.m1_req_ack, ib.owner} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_fx got=%b exp=00000",
               {ib.s_req, ib.busy, ib.m0_req_ack, ib.m1_req_ack, ib.owner});
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_single_read();
    logic [5:0] sreq_tab;
    sreq_tab = 6'b001110;
    ia.m0_addr = 32'h100; ia.m0_we = 0; ia.m0_size = 2'd2; ia.m0_wd = $urandom;
    for (int c = 0; c < 6; c++) begin
      ia.m0_req = (c <= 3);
      ia.s_req_ack = (c == 3);
      ia.s_rd = (c == 3) ? 32'h12345678 : $urandom;
      #1;
      exp = model_out(); got = pack_dut();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL read_model cyc=%0d got=%h exp=%h", c, got, exp);
      end
      n_cmp++;
      if (ia.s_req !== sreq_tab[c]) begin
        n_bad++;
        $display("FAIL read_sreq cyc=%0d got=%b exp=%b", c, ia.s_req, sreq_tab[c]);
      end
      if (c == 1) begin
        n_cmp++;
        if (ia.s_addr !== 32'h100) begin
          n_bad++;
          $display("FAIL read_addr got=%h exp=00000100", ia.s_addr);
        end
      end
      if (c == 3) begin
        n_cmp++;
        if ({ia.m0_req_ack, ia.m0_rd, ia.m1_req_ack} !== {1'b1, 32'h12345678, 1'b0}) begin
          n_bad++;
          $display("FAIL read_ack got=%b/%h/%b exp=1/12345678/0",
                   ia.m0_req_ack, ia.m0_rd, ia.m1_req_ack);
        end
      end
      model_step();
      @(negedge clk);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] gtab;
    int ng;
    gtab = 4'b1010;
    ng = 0;
    pulse_reset();
    ia.m0_addr = 32'h1000; ia.m0_we = 0;
    ia.m1_addr = 32'h2000; ia.m1_we = 0;
    ia.m0_req = 1; ia.m1_req = 1;
    for (int c = 0; c < 8; c++) begin
      ia.s_req_ack = ia.s_req;
      ia.s_rd = $urandom;
      #1;
      exp = model_out(); got = pack_dut();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL rr_model cyc=%0d got=%h exp=%h", c, got, exp);
      end
      if (ia.s_req === 1'b1) begin
        n_cmp++;
        if (ng >= 4 || ia.owner !== gtab[ng]) begin
          n_bad++;
          $display("FAIL rr_grant n=%0d got=%b exp=%b", ng, ia.owner, gtab[ng % 4]);
        end
        ng++;
      end
      model_step();
      @(negedge clk);
    end
    n_cmp++;
    if (ng !== 4) begin
      n_bad++;
      $display("FAIL rr_count got=%0d exp=4", ng);
    end
    ia.m0_req = 0; ia.m1_req = 0;
  endtask

  task automatic test_write_contend();
    ia.m1_addr = 32'h200; ia.m1_wd = 32'hCAFEF00D; ia.m1_we = 1; ia.m1_size = 2'd2;
    ia.m0_addr = 32'h300; ia.m0_wd = $urandom; ia.m0_we = 0; ia.m0_size = 2'd1;
    for (int c = 0; c < 7; c++) begin
      ia.m1_req = (c <= 3);
      ia.m0_req = (c >= 2 && c <= 5);
      ia.s_req_ack = (c == 3 || c == 5);
      ia.s_rd = $urandom;
      #1;
      exp = model_out(); got = pack_dut();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL wr_model cyc=%0d got=%h exp=%h", c, got, exp);
      end
      if (c >= 1 && c <= 3) begin
        n_cmp++;
        if ({ia.s_req, ia.s_we, ia.s_wd, ia.s_size, ia.s_addr, ia.owner} !==
            {1'b1, 1'b1, 32'hCAFEF00D, 2'd2, 32'h200, 1'b1}) begin
          n_bad++;
          $display("FAIL wr_bus cyc=%0d got=%b/%b/%h/%0d/%h/%b", c,
                   ia.s_req, ia.s_we, ia.s_wd, ia.s_size, ia.s_addr, ia.owner);
        end
      end
      if (c == 4) begin
        n_cmp++;
        if (ia.s_req !== 1'b0) begin
          n_bad++;
          $display("FAIL wr_gap got=%b exp=0", ia.s_req);
        end
      end
      if (c == 5) begin
        n_cmp++;
        if ({ia.s_req, ia.owner, ia.s_addr, ia.m0_req_ack, ia.m1_req_ack} !==
            {1'b1, 1'b0, 32'h300, 1'b1, 1'b0}) begin
          n_bad++;
          $display("FAIL wr_m0_grant got=%b/%b/%h/%b/%b exp=1/0/00000300/1/0",
                   ia.s_req, ia.owner, ia.s_addr, ia.m0_req_ack, ia.m1_req_ack);
        end
      end
      model_step();
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midbusy();
    ia.m0_addr = 32'h400; ia.m1_addr = 32'h500;
    ia.m0_req = 1; ia.m1_req = 1; ia.s_req_ack = 0;
    for (int c = 0; c < 2; c++) begin
      #1;
      exp = model_out(); got = pack_dut();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL mrst_pre cyc=%0d got=%h exp=%h", c, got, exp);
      end
      model_step();
      @(negedge clk);
    end
    ia.s_req_ack = 1;
    resetn = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({ia.s_req, ia.busy, ia.m0_req_ack, ia.m1_req_ack} !== 4'b0) begin
      n_bad++;
      $display("FAIL mrst_drop got=%b exp=0000",
               {ia.s_req, ia.busy, ia.m0_req_ack, ia.m1_req_ack});
    end
    @(negedge clk);
    resetn = 1'b1;
    ia.s_req_ack = 0;
    #1;
    exp = model_out(); got = pack_dut();
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL mrst_idle got=%h exp=%h", got, exp);
    end
    model_step();
    @(negedge clk);
    ia.s_req_ack = 1;
    #1;
    n_cmp++;
    if ({ia.s_req, ia.owner} !== 2'b10) begin
      n_bad++;
      $display("FAIL mrst_tie got=%b exp=10", {ia.s_req, ia.owner});
    end
    model_step();
    @(negedge clk);
    ia.m0_req = 0; ia.m1_req = 0; ia.s_req_ack = 0;
    #1;
    exp = model_out(); got = pack_dut();
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL mrst_post got=%h exp=%h", got, exp);
    end
    model_step();
    @(negedge clk);
  endtask

  task automatic test_random();
    bit p0, p1;
    p0 = 0; p1 = 0;
    for (int c = 0; c < 400; c++) begin
      if (!p0 && $urandom_range(0, 2) == 0) begin
        p0 = 1;
        ia.m0_addr = $urandom; ia.m0_wd = $urandom;
        ia.m0_we = 1'($urandom_range(0, 1)); ia.m0_size = 2'($urandom_range(0, 3));
      end else if (p0 && $urandom_range(0, 19) == 0) begin
        p0 = 0;
      end
      if (!p1 && $urandom_range(0, 2) == 0) begin
        p1 = 1;
        ia.m1_addr = $urandom; ia.m1_wd = $urandom;
        ia.m1_we = 1'($urandom_range(0, 1)); ia.m1_size = 2'($urandom_range(0, 3));
      end else if (p1 && $urandom_range(0, 19) == 0) begin
        p1 = 0;
      end
      ia.m0_req = p0;
      ia.m1_req = p1;
      ia.s_req_ack = 1'($urandom_range(0, 1));
      ia.s_rd = $urandom;
      #1;
      exp = model_out(); got = pack_dut();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL rand_model cyc=%0d got=%h exp=%h", c, got, exp);
      end
      if (exp[A0_BIT]) p0 = 0;
      if (exp[A1_BIT]) p1 = 0;
      model_step();
      @(negedge clk);
    end
    ia.m0_req = 0; ia.m1_req = 0; ia.s_req_ack = 0;
  endtask

`ifdef SIMPLE_MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    pulse_reset();
    ia.m0_addr = 32'h600; ia.m0_we = 0; ia.m0_size = 2'd2;
    ia.m1_req = 0;
    for (int c = 0; c < 8; c++) begin
      ia.m0_req = (c <= 5);
      ia.s_req_ack = (c == 6);
      ia.s_rd = $urandom;
      #1;
      exp = model_out(); got = pack_dut();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL to_model cyc=%0d got=%h exp=%h", c, got, exp);
      end
      n_cmp++;
      if (ia.err !== (c == 5)) begin
        n_bad++;
        $display("FAIL to_err cyc=%0d got=%b exp=%b", c, ia.err, (c == 5));
      end
      if (c == 5) begin
        n_cmp++;
        if ({ia.m0_req_ack, ia.m0_rd, ia.s_req} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
          n_bad++;
          $display("FAIL to_force got=%b/%h/%b exp=1/deadbeef/0",
                   ia.m0_req_ack, ia.m0_rd, ia.s_req);
        end
      end
      if (c == 6) begin
        n_cmp++;
        if ({ia.s_req, ia.m0_req_ack, ia.m1_req_ack} !== 3'b0) begin
          n_bad++;
          $display("FAIL to_late_ack got=%b exp=000",
                   {ia.s_req, ia.m0_req_ack, ia.m1_req_ack});
        end
      end
      model_step();
      @(negedge clk);
    end
  endtask
`endif

  task automatic test_fixed_prio();
    int ng;
    bit eo;
    ng = 0;
    ib.m0_addr = 32'h700; ib.m1_addr = 32'h800;
    ib.m1_req = 1;
    for (int c = 0; c < 13; c++) begin
      ib.m0_req = (c < 10);
      ib.s_req_ack = ib.s_req;
      ib.s_rd = $urandom;
      #1;
      if (ib.s_req === 1'b1) begin
        eo = (c >= 10);
        n_cmp++;
        if (ng >= 6 || {ib.owner, ib.m0_req_ack, ib.m1_req_ack} !== {eo, !eo, eo}) begin
          n_bad++;
          $display("FAIL fx_grant cyc=%0d got=%b exp=%b", c,
                   {ib.owner, ib.m0_req_ack, ib.m1_req_ack}, {eo, !eo, eo});
        end
        ng++;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (ng !== 6) begin
      n_bad++;
      $display("FAIL fx_count got=%0d exp=6", ng);
    end
    ib.m0_req = 0; ib.m1_req = 0; ib.s_req_ack = 0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_contend();
    test_reset_midbusy();
    test_random();
`ifdef SIMPLE_MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_fixed_prio();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
